// File: rtl/msdap_conv_engine_if.sv
// rtl/msdap_conv_engine_if.sv - signal bundle between msdap_conv_engine and its neighbours
// Purpose: groups table loading, the sample-in handshake, the result-out handshake and the
//    debug taps of the convolution engine into one bundle.
//    master = controlling side (config host, deframer, serialiser); slave = the engine.
// Signals: cfgWrite/cfgAddr/cfgData/cfgDone  table load, cfgDone leaves CFG
//          flush                             clears the sample count while waiting
//          sampleIn/sampleValid/sampleReady  one sample per channel, packed
//          yOut/yValid/yReady                one result per channel, packed, held until taken
//          currentUj/status                  last finished u_j and engine state code
interface msdap_conv_engine_if #(
   parameter int DATA_W   = 16,
   parameter int ACC_W    = 40,
   parameter int CHANNELS = 2,
   parameter int CFG_AW   = 10
);
   logic                         cfgWrite;
   logic [CFG_AW-1:0]            cfgAddr;
   logic [15:0]                  cfgData;
   logic                         cfgDone;
   logic                         flush;
   logic [CHANNELS*DATA_W-1:0]   sampleIn;
   logic                         sampleValid;
   logic                         sampleReady;
   logic [CHANNELS*ACC_W-1:0]    yOut;
   logic                         yValid;
   logic                         yReady;
   logic [ACC_W-1:0]             currentUj;
   logic [3:0]                   status;

   modport master (
      output cfgWrite, cfgAddr, cfgData, cfgDone, flush, sampleIn, sampleValid, yReady,
      input  sampleReady, yOut, yValid, currentUj, status
   );

   modport slave (
      input  cfgWrite, cfgAddr, cfgData, cfgDone, flush, sampleIn, sampleValid, yReady,
      output sampleReady, yOut, yValid, currentUj, status
   );
endinterface

// File: rtl/msdap_conv_engine.sv
// rtl/msdap_conv_engine.sv - time-multiplexed MSDAP rj/coefficient convolution engine
// Purpose: holds the rj and coefficient tables plus a circular sample history per channel and
//    computes y(n) = sum_j 2^-(NUM_RJ-j) * u_j, u_j = sum(+/-x(n-k)), one coefficient per cycle,
//    channel after channel on a single adder.
// Ports: clk    rising-edge clock
//        reset  asynchronous, active-high; returns to CFG, tables must be reloaded
//        bus    msdap_conv_engine_if.slave (table load, sample in, y out, debug)
module msdap_conv_engine #(
   parameter int DATA_W    = 16,
   parameter int ACC_W     = 40,
   parameter int NUM_RJ    = 16,
   parameter int NUM_COEFF = 512,
   parameter int HIST_AW   = 8,
   parameter int CHANNELS  = 2
) (
   input logic clk,
   input logic reset,
   msdap_conv_engine_if.slave bus
);
   localparam int CFG_AW = $clog2(NUM_RJ + NUM_COEFF);
   localparam int RJ_AW  = (NUM_RJ > 1) ? $clog2(NUM_RJ) : 1;
   localparam int CO_AW  = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
   localparam int CH_AW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PAD_W  = ACC_W - DATA_W - 16;

   typedef enum logic [3:0] {
      ST_CFG = 4'd0, ST_WAIT = 4'd1, ST_STORE = 4'd2, ST_ACCUM = 4'd3,
      ST_SHIFT = 4'd4, ST_NEXTCH = 4'd5, ST_OUT = 4'd6
   } state_t;

   state_t                      state;
   logic [30:0]                 n;
   logic [CH_AW-1:0]            ch;
   logic [RJ_AW-1:0]            j;
   logic [8:0]                  cnt;
   logic [CO_AW-1:0]            ptr;
   logic [ACC_W-1:0]            accU, yAcc, currentUjReg;
   logic [CHANNELS*DATA_W-1:0]  sampleReg;
   logic [CHANNELS*ACC_W-1:0]   yOutReg;
   logic                        yValidReg, sampleReadyReg;

   // Tables and history are plain storage: not reset, contents undefined until loaded.
   logic [8:0]         rjTab    [NUM_RJ];
   logic [8:0]         coeffTab [NUM_COEFF];
   logic [DATA_W-1:0]  hist     [CHANNELS][2**HIST_AW];

   logic [8:0]              coeffNow, rjNext;
   logic [7:0]              kNow;
   logic [HIST_AW-1:0]      rdIdx;
   logic [DATA_W-1:0]       xRead;
   logic [ACC_W-1:0]        xAligned, term;
   logic signed [ACC_W-1:0] shiftSum;
   logic [RJ_AW-1:0]        jSel;
   logic [CO_AW-1:0]        ptrInc;
   logic                    unusedCfgBits;

   assign unusedCfgBits = ^bus.cfgData[15:9];

   always_comb begin
      coeffNow = coeffTab[ptr];
      kNow     = coeffNow[7:0];
      rdIdx    = n[HIST_AW-1:0] - HIST_AW'(kNow);
      xRead    = hist[ch][rdIdx];
      // Sample sits above 16 fractional bits so that NUM_RJ right shifts stay exact.
      xAligned = {{PAD_W{xRead[DATA_W-1]}}, xRead, 16'b0};
      // Taps reaching before the first sample since reset/flush contribute nothing.
      if (31'(kNow) > n)
         term = '0;
      else if (coeffNow[8])
         term = -xAligned;
      else
         term = xAligned;
      shiftSum = yAcc + accU;
      // Group about to start: next one after a SHIFT, otherwise group 0 of a fresh channel.
      jSel   = (state == ST_SHIFT) ? j + RJ_AW'(1) : '0;
      rjNext = rjTab[jSel];
      ptrInc = (ptr == CO_AW'(NUM_COEFF - 1)) ? '0 : ptr + CO_AW'(1);
   end

   always_ff @(posedge clk) begin
      if (state == ST_CFG && bus.cfgWrite) begin
         if (bus.cfgAddr < CFG_AW'(NUM_RJ))
            rjTab[bus.cfgAddr[RJ_AW-1:0]] <= bus.cfgData[8:0];
         else if (bus.cfgAddr < CFG_AW'(NUM_RJ + NUM_COEFF))
            coeffTab[CO_AW'(bus.cfgAddr - CFG_AW'(NUM_RJ))] <= bus.cfgData[8:0];
      end
      if (state == ST_STORE)
         for (int c = 0; c < CHANNELS; c++)
            hist[c][n[HIST_AW-1:0]] <= sampleReg[c*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_CFG;
         n              <= '0;
         ch             <= '0;
         j              <= '0;
         cnt            <= '0;
         ptr            <= '0;
         accU           <= '0;
         yAcc           <= '0;
         currentUjReg   <= '0;
         sampleReg      <= '0;
         yOutReg        <= '0;
         yValidReg      <= 1'b0;
         sampleReadyReg <= 1'b0;
      end else begin
         case (state)
            ST_CFG: begin
               if (bus.cfgDone) begin
                  state          <= ST_WAIT;
                  sampleReadyReg <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (bus.flush) begin
                  n <= '0;
               end else if (bus.sampleValid) begin
                  sampleReg      <= bus.sampleIn;
                  sampleReadyReg <= 1'b0;
                  state          <= ST_STORE;
               end
            end
            ST_STORE, ST_NEXTCH: begin
               if (state == ST_NEXTCH)
                  yOutReg[ch*ACC_W +: ACC_W] <= yAcc;
               if (state == ST_NEXTCH && ch == CH_AW'(CHANNELS - 1)) begin
                  yValidReg <= 1'b1;
                  state     <= ST_OUT;
               end else begin
                  ch    <= (state == ST_STORE) ? '0 : ch + CH_AW'(1);
                  j     <= '0;
                  ptr   <= '0;
                  accU  <= '0;
                  yAcc  <= '0;
                  cnt   <= rjNext;
                  state <= (rjNext == 9'd0) ? ST_SHIFT : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               accU <= accU + term;
               ptr  <= ptrInc;
               cnt  <= cnt - 9'd1;
               if (cnt == 9'd1)
                  state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               yAcc         <= shiftSum >>> 1;
               currentUjReg <= accU;
               accU         <= '0;
               if (j == RJ_AW'(NUM_RJ - 1)) begin
                  state <= ST_NEXTCH;
               end else begin
                  j     <= jSel;
                  cnt   <= rjNext;
                  state <= (rjNext == 9'd0) ? ST_SHIFT : ST_ACCUM;
               end
            end
            ST_OUT: begin
               if (bus.yReady) begin
                  yValidReg      <= 1'b0;
                  sampleReadyReg <= 1'b1;
                  n              <= (n == '1) ? n : n + 31'd1;
                  state          <= ST_WAIT;
               end
            end
            default: state <= ST_CFG;
         endcase
      end
   end

   assign bus.status      = state;
   assign bus.yOut        = yOutReg;
   assign bus.yValid      = yValidReg;
   assign bus.sampleReady = sampleReadyReg;
   assign bus.currentUj   = currentUjReg;
endmodule

// File: tb/tb_msdap_conv_engine.sv
// tb/tb_msdap_conv_engine.sv - self-checking bench for msdap_conv_engine
module tb_msdap_conv_engine;
   localparam int DW  = 16;
   localparam int AW  = 40;
   localparam int NRJ = 16;
   localparam int NCO = 512;
   localparam int CH  = 2;
   localparam int CAW = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   msdap_conv_engine_if #(.DATA_W(DW), .ACC_W(AW), .CHANNELS(CH), .CFG_AW(CAW)) bus ();

   msdap_conv_engine #(
      .DATA_W(DW), .ACC_W(AW), .NUM_RJ(NRJ), .NUM_COEFF(NCO), .HIST_AW(8), .CHANNELS(CH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: tables as loaded, every sample since the last flush/reset, and n.
   int mRj    [NRJ];
   int mCoeff [NCO];
   int mHist  [CH][0:1023];
   int mN;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // y = sum_j u_j * 2^j / 2^NRJ with u_j scaled by 2^16, i.e. sum_j usamp_j * 2^j exactly.
   function automatic logic [AW-1:0] modelY(input int c);
      longint y = 0;
      int p = 0;
      for (int g = 0; g < NRJ; g++) begin
         longint u = 0;
         for (int t = 0; t < mRj[g]; t++) begin
            int k = mCoeff[p] & 255;
            if (k <= mN)
               u += ((mCoeff[p] >> 8) & 1) ? -longint'(mHist[c][mN-k]) : longint'(mHist[c][mN-k]);
            p = (p + 1) % NCO;
         end
         y += u <<< g;
      end
      return AW'(y);
   endfunction

   function automatic int sumRj();
      int s = 0;
      for (int g = 0; g < NRJ; g++) s += mRj[g];
      return s;
   endfunction

   task automatic cfgWr(input int a, input int d);
      bus.cfgWrite = 1'b1;
      bus.cfgAddr  = CAW'(a);
      bus.cfgData  = {7'($urandom), 9'(d)};
      tick();
      bus.cfgWrite = 1'b0;
   endtask

   task automatic resetAndLoad();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      mN = 0;
      for (int i = 0; i < NRJ; i++) cfgWr(i, mRj[i]);
      for (int i = 0; i < NCO; i++) cfgWr(NRJ + i, mCoeff[i]);
      bus.cfgDone = 1'b1;
      tick();
      bus.cfgDone = 1'b0;
      chk("cfg_status_wait", 64'(bus.status), 64'd1);
   endtask

   task automatic clearModel();
      for (int i = 0; i < NRJ; i++) mRj[i] = 0;
      for (int i = 0; i < NCO; i++) mCoeff[i] = 0;
   endtask

   task automatic runSample(input string tag, input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                            input int stall, output logic [AW-1:0] y0);
      int w;
      logic [AW-1:0] e0, e1;
      logic [CH*AW-1:0] held;
      w = 0;
      while (bus.sampleReady !== 1'b1 && w < 100) begin tick(); w++; end
      chk({tag, "_ready"}, 64'(bus.sampleReady), 64'd1);
      bus.sampleIn    = {x1, x0};
      bus.sampleValid = 1'b1;
      tick();
      bus.sampleValid = 1'b0;
      bus.sampleIn    = CH*DW'($urandom);
      mHist[0][mN] = int'($signed(x0));
      mHist[1][mN] = int'($signed(x1));
      e0 = modelY(0);
      e1 = modelY(1);
      w = 0;
      while (bus.yValid !== 1'b1 && w < 20000) begin tick(); w++; end
      chk({tag, "_latency"}, 64'(w), 64'(2 + CH * (sumRj() + NRJ) + 1));
      chk({tag, "_y0"}, 64'(bus.yOut[0 +: AW]), 64'(e0));
      chk({tag, "_y1"}, 64'(bus.yOut[AW +: AW]), 64'(e1));
      y0   = bus.yOut[0 +: AW];
      held = bus.yOut;
      for (int s = 0; s < stall; s++) begin
         tick();
         chk({tag, "_stall_valid"}, 64'(bus.yValid), 64'd1);
         chk({tag, "_stall_ready"}, 64'(bus.sampleReady), 64'd0);
         chk({tag, "_stall_yout"}, 64'(bus.yOut != held), 64'd0);
      end
      bus.yReady = 1'b1;
      tick();
      bus.yReady = 1'b0;
      chk({tag, "_valid_drop"}, 64'(bus.yValid), 64'd0);
      if (mN < 2147483647) mN++;
   endtask

   initial begin
      logic [AW-1:0] y;
      int w;
      reset = 1'b1;
      bus.cfgWrite = 1'b0; bus.cfgAddr = '0; bus.cfgData = '0; bus.cfgDone = 1'b0;
      bus.flush = 1'b0; bus.sampleIn = '0; bus.sampleValid = 1'b0; bus.yReady = 1'b0;
      tick();
      tick();
      chk("rst_status", 64'(bus.status), 64'd0);
      chk("rst_yvalid", 64'(bus.yValid), 64'd0);
      chk("rst_ready", 64'(bus.sampleReady), 64'd0);
      chk("rst_yout", 64'(bus.yOut != '0), 64'd0);
      chk("rst_uj", 64'(bus.currentUj), 64'd0);

      // Single tap in group 0, positive then negative.
      clearModel();
      mRj[0] = 1;
      resetAndLoad();
      runSample("a", 16'h4000, 16'h0000, 0, y);
      chk("a_const", 64'(y), 64'h00_0000_4000);
      mCoeff[0] = 'h100;
      resetAndLoad();
      runSample("b", 16'h4000, 16'h0000, 0, y);
      chk("b_const", 64'(y), 64'hFF_FFFF_C000);

      // Single tap in the last group: one shift only.
      clearModel();
      mRj[NRJ-1] = 1;
      resetAndLoad();
      runSample("c", 16'h4000, 16'($urandom), 0, y);
      chk("c_const", 64'(y), 64'h00_2000_0000);

      // Delay tap k=1, ignored write outside CFG, flush priority, stall in OUT.
      clearModel();
      mRj[0] = 1;
      mCoeff[0] = 'h001;
      resetAndLoad();
      runSample("d0", 16'h1234, 16'($urandom), 0, y);
      chk("d0_const", 64'(y), 64'd0);
      cfgWr(NRJ, 'h000);
      runSample("d1", 16'h0000, 16'($urandom), 10, y);
      chk("d1_const", 64'(y), 64'h00_0000_1234);
      bus.flush       = 1'b1;
      bus.sampleValid = 1'b1;
      tick();
      bus.flush       = 1'b0;
      bus.sampleValid = 1'b0;
      chk("flush_stay_wait", 64'(bus.status), 64'd1);
      mN = 0;
      runSample("d2", 16'h5555, 16'($urandom), 0, y);
      chk("d2_const", 64'(y), 64'd0);

      // Random tables and samples, with an occasional flush.
      clearModel();
      for (int i = 0; i < NRJ; i++) mRj[i] = $urandom_range(0, 3);
      for (int i = 0; i < NCO; i++) mCoeff[i] = ($urandom_range(0, 1) << 8) | $urandom_range(0, 7);
      resetAndLoad();
      for (int s = 0; s < 10; s++) begin
         if (s == 6) begin
            bus.flush = 1'b1;
            tick();
            bus.flush = 1'b0;
            mN = 0;
         end
         runSample("rnd", 16'($urandom), 16'($urandom), 0, y);
      end

      // Coefficient pointer wrapping past the table end.
      clearModel();
      mRj[0] = 300;
      mRj[1] = 230;
      for (int i = 0; i < NCO; i++) mCoeff[i] = ($urandom_range(0, 1) << 8) | $urandom_range(0, 3);
      resetAndLoad();
      runSample("wrap0", 16'($urandom), 16'($urandom), 0, y);
      runSample("wrap1", 16'($urandom), 16'($urandom), 0, y);

      // Reset while accumulating.
      w = 0;
      bus.sampleIn    = CH*DW'($urandom);
      bus.sampleValid = 1'b1;
      tick();
      bus.sampleValid = 1'b0;
      while (bus.status !== 4'd3 && w < 200) begin tick(); w++; end
      chk("abort_reached_accum", 64'(bus.status), 64'd3);
      #2 reset = 1'b1;
      #1;
      chk("abort_status", 64'(bus.status), 64'd0);
      chk("abort_yvalid", 64'(bus.yValid), 64'd0);
      chk("abort_ready", 64'(bus.sampleReady), 64'd0);
      tick();
      reset = 1'b0;
      for (int s = 0; s < 5; s++) tick();
      chk("abort_hold_status", 64'(bus.status), 64'd0);
      chk("abort_hold_ready", 64'(bus.sampleReady), 64'd0);
      chk("abort_hold_yvalid", 64'(bus.yValid), 64'd0);
      bus.cfgDone = 1'b1;
      tick();
      bus.cfgDone = 1'b0;
      chk("abort_cfgdone_ready", 64'(bus.sampleReady), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
